// File: rtl/accum_counter_pkg.sv
// Shared constants for the accumulating counter: SATURATE mode encodings and default widths.
// Imported by the top and by the adder so both agree on parameter defaults.
package accum_counter_pkg;

  // Values accepted by the SATURATE parameter of accum_counter.
  localparam int ACC_WRAP = 0;
  localparam int ACC_SAT  = 1;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STEP_W = 8;

endpackage : accum_counter_pkg

// File: rtl/accum_counter_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of gate-level full-adder cells.
// Purely combinational; the carry chain length sets the critical path of accum_counter.
module ripple_adder
  import accum_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic half;
    assign half       = a[i] ^ b[i];
    assign sum[i]     = half ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & half);
  end

  assign cout = carry[WIDTH];

endmodule : ripple_adder

// File: rtl/accum_counter.sv
// Registered accumulator: each accepted step is added to a running total, and the result
// sits in a one-entry output register with a valid/ready handshake and a sticky overflow.
module accum_counter
  import accum_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int SATURATE = ACC_WRAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STEP_W-1:0] in_step,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_stat,
  output logic              ovf_sticky
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] acc_next;
  logic             accept;
  logic             drain;

  assign step_ext = WIDTH'(in_step);

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc),
    .b    (step_ext),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: every signal driven in always_comb gets a value on every path (default first),
  // otherwise synthesis infers a latch.
  always_comb begin
    acc_next = add_sum;
    if (SATURATE == ACC_SAT && add_cout) begin
      acc_next = '1;
    end
  end

  // The output register can take a new result when it is empty or being emptied this cycle.
  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      out_sum    <= '0;
      out_stat   <= 1'b0;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      out_sum    <= '0;
      out_stat   <= 1'b0;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      acc        <= acc_next;
      out_sum    <= acc_next;
      out_stat   <= add_cout;
      out_valid  <= 1'b1;
      ovf_sticky <= ovf_sticky | add_cout;
    end else if (drain) begin
      out_valid  <= 1'b0;
    end
  end

endmodule : accum_counter

// File: tb/tb_accum_counter.sv
// Scoreboard bench for accum_counter: a 2-bit wrapping instance and an 8-bit saturating
// instance share one handshake stream; an arithmetic model predicts every result.
module tb_accum_counter;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] step;

  logic       rdy_a, vld_a, stat_a, sticky_a;
  logic [1:0] sum_a;
  logic       rdy_b, vld_b, stat_b, sticky_b;
  logic [7:0] sum_b;

  int n_checks = 0;
  int n_errors = 0;

  accum_counter #(.WIDTH(2), .STEP_W(2), .SATURATE(0)) u_wrap2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (rdy_a),
    .in_step    (step[1:0]),
    .out_valid  (vld_a),
    .out_ready  (out_ready),
    .out_sum    (sum_a),
    .out_stat   (stat_a),
    .ovf_sticky (sticky_a)
  );

  accum_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(1)) u_sat8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (rdy_b),
    .in_step    (step),
    .out_valid  (vld_b),
    .out_ready  (out_ready),
    .out_sum    (sum_b),
    .out_stat   (stat_b),
    .ovf_sticky (sticky_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint sum;
    bit     stat;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  longint m_total[2] = '{0, 0};
  bit     m_sticky[2] = '{0, 0};
  bit     m_valid = 0;

  // Unsigned add of a step to a total of w bits, either wrapping or clamping on overflow.
  function automatic void model_add(input int w, input bit sat, input longint total,
                                    input longint inc, output longint nxt, output bit c);
    longint lim;
    longint raw;
    lim = longint'(1) << w;
    raw = total + inc;
    c   = (raw >= lim);
    if (!c)       nxt = raw;
    else if (sat) nxt = lim - 1;
    else          nxt = raw - lim;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint nxt;
    bit     c;
    if (!rst_n || clr) begin
      m_total  = '{0, 0};
      m_sticky = '{0, 0};
      m_valid  = 0;
      q_a.delete();
      q_b.delete();
    end else if (in_valid && (!m_valid || out_ready)) begin
      model_add(2, 1'b0, m_total[0], longint'(step) % 4, nxt, c);
      m_total[0] = nxt;
      m_sticky[0] |= c;
      q_a.push_back('{sum: nxt, stat: c});
      model_add(8, 1'b1, m_total[1], longint'(step), nxt, c);
      m_total[1] = nxt;
      m_sticky[1] |= c;
      q_b.push_back('{sum: nxt, stat: c});
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    bit   exp_rdy;
    if (!rst_n) begin
      check("rst_valid_a", vld_a, 0);
      check("rst_valid_b", vld_b, 0);
      check("rst_sum_b", sum_b, 0);
    end else begin
      exp_rdy = !clr && (!m_valid || out_ready);
      check("in_ready_a", rdy_a, exp_rdy);
      check("in_ready_b", rdy_b, exp_rdy);
      check("out_valid_a", vld_a, m_valid);
      check("out_valid_b", vld_b, m_valid);
      check("sticky_a", sticky_a, m_sticky[0]);
      check("sticky_b", sticky_b, m_sticky[1]);
      if (!vld_a) check("held_sum_a", sum_a, m_total[0]);
      if (!vld_b) check("held_sum_b", sum_b, m_total[1]);
      if (vld_a && out_ready && !clr) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_a: result presented with no expected entry at %0t", $time);
        end else begin
          e = q_a.pop_front();
          check("sb_sum_a", sum_a, e.sum);
          check("sb_stat_a", stat_a, e.stat);
        end
      end
      if (vld_b && out_ready && !clr) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_b: result presented with no expected entry at %0t", $time);
        end else begin
          e = q_b.pop_front();
          check("sb_sum_b", sum_b, e.sum);
          check("sb_stat_b", stat_b, e.stat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_w2[4];
    exp_w2 = '{1, 2, 3, 0};
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step      = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("t1_valid", vld_b, 0);
    check("t1_sum", sum_b, 0);
    check("t1_sticky", sticky_b, 0);
    check("t1_in_ready", rdy_b, 1);

    // 2-bit wrap counting by one.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step      = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_sum_w2", sum_a, exp_w2[i]);
      check("t2_stat_w2", stat_a, (i == 3) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("t2_sticky_w2", sticky_a, 1);

    // 8-bit saturation.
    clr = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b1;
    step     = 8'd200;
    tick();
    check("t3_sum_200", sum_b, 200);
    check("t3_stat_200", stat_b, 0);
    step = 8'd100;
    tick();
    check("t3_sum_sat", sum_b, 255);
    check("t3_stat_sat", stat_b, 1);
    step = 8'd1;
    tick();
    check("t3_sum_hold", sum_b, 255);
    check("t3_stat_hold", stat_b, 1);
    check("t3_sticky", sticky_b, 1);
    in_valid = 1'b0;

    // Backpressure, then drain and accept in the same cycle.
    clr = 1'b1;
    tick();
    clr       = 1'b0;
    in_valid  = 1'b1;
    step      = 8'd3;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    step      = 8'd7;
    #1 check("t4_stall_ready", rdy_b, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_sum", sum_b, 3);
      check("t4_stall_valid", vld_b, 1);
    end
    out_ready = 1'b1;
    #1 check("t4_release_ready", rdy_b, 1);
    tick();
    check("t4_pass_sum", sum_b, 10);
    check("t4_pass_valid", vld_b, 1);
    in_valid = 1'b0;
    tick();
    check("t4_drained_valid", vld_b, 0);
    check("t4_drained_sum", sum_b, 10);

    // Clear wins over a pending accept.
    in_valid  = 1'b1;
    step      = 8'd4;
    out_ready = 1'b0;
    tick();
    check("t5_pre_sum", sum_b, 14);
    clr = 1'b1;
    #1 check("t5_clr_ready", rdy_b, 0);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("t5_valid", vld_b, 0);
    check("t5_sum", sum_b, 0);
    check("t5_sticky_a", sticky_a, 0);
    check("t5_sticky_b", sticky_b, 0);
    out_ready = 1'b1;
    tick();
    check("t5_not_accepted", vld_b, 0);

    // Asynchronous reset between clock edges.
    in_valid = 1'b1;
    step     = 8'd5;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", vld_b, 0);
    check("t6_async_sum_b", sum_b, 0);
    check("t6_async_sum_a", sum_a, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    step     = 8'd5;
    tick();
    check("t6_first_sum_b", sum_b, 5);
    check("t6_first_sum_a", sum_a, 1);
    in_valid = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      clr       = ($urandom_range(0, 39) == 0);
      step      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 12));
    end

    tick();
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("final_queue_a", q_a.size(), 0);
    check("final_queue_b", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_accum_counter
